// File: rtl/tone_sequencer.sv
// Step sequencer driving tone generator wave/freq selects and gate.
// Steps are timed in audio sample ticks; one-shot or looped playback.
module tone_sequencer #(
  parameter  int DEPTH  = 16,
  parameter  int DUR_W  = 16,
  parameter  int FREQ_W = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_we_i,
  input  logic [AW-1:0]     cfg_addr_i,
  input  logic [1:0]        cfg_wave_i,
  input  logic [FREQ_W-1:0] cfg_freq_i,
  input  logic              cfg_rest_i,
  input  logic [DUR_W-1:0]  cfg_dur_i,
  input  logic [AW:0]       len_i,
  input  logic              loop_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              sample_tick_i,
  output logic [1:0]        wave_sel_o,
  output logic [FREQ_W-1:0] freq_sel_o,
  output logic              gate_o,
  output logic [AW-1:0]     step_o,
  output logic              step_adv_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY
  } state_e;

  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  logic [1:0]        wave_mem [DEPTH];
  logic [FREQ_W-1:0] freq_mem [DEPTH];
  logic              rest_mem [DEPTH];
  logic [DUR_W-1:0]  dur_mem  [DEPTH];

  state_e            state_q, state_d;
  logic [AW:0]       len_q, len_d;
  logic              loop_q, loop_d;
  logic [AW-1:0]     step_q, step_d;
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        wave_q, wave_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              gate_q, gate_d;
  logic              adv_q, adv_d;
  logic              done_q, done_d;

  logic [1:0]        ent_wave;
  logic [FREQ_W-1:0] ent_freq;
  logic              ent_rest;
  logic [DUR_W-1:0]  ent_dur;
  logic [AW:0]       step_nx;
  logic              last;
  logic              do_adv;
  logic              abort;

  assign ent_wave = wave_mem[step_q];
  assign ent_freq = freq_mem[step_q];
  assign ent_rest = rest_mem[step_q];
  assign ent_dur  = dur_mem[step_q];
  assign step_nx  = {1'b0, step_q} + (AW+1)'(1);
  assign last     = (step_nx >= len_q);

  // Step table write port; contents are only read when a step loads.
  always_ff @(posedge clk_i) begin
    if (cfg_we_i) begin
      wave_mem[cfg_addr_i] <= cfg_wave_i;
      freq_mem[cfg_addr_i] <= cfg_freq_i;
      rest_mem[cfg_addr_i] <= cfg_rest_i;
      dur_mem[cfg_addr_i]  <= cfg_dur_i;
    end
  end

  // Next-state, step advance, and output register updates.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    loop_d  = loop_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    wave_d  = wave_q;
    freq_d  = freq_q;
    gate_d  = gate_q;
    adv_d   = 1'b0;
    done_d  = 1'b0;
    do_adv  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          if (len_i != '0) begin
            len_d   = (len_i > LEN_MAX) ? LEN_MAX : len_i;
            loop_d  = loop_i;
            step_d  = '0;
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (stop_i) begin
          abort = 1'b1;
        end else if (ent_dur != '0) begin
          wave_d  = ent_wave;
          freq_d  = ent_freq;
          gate_d  = ~ent_rest;
          cnt_d   = ent_dur;
          adv_d   = 1'b1;
          state_d = PLAY;
        end else begin
          do_adv = 1'b1;
        end
      end
      PLAY: begin
        if (stop_i) begin
          abort = 1'b1;
        end else if (sample_tick_i) begin
          if (cnt_q == DUR_W'(1)) begin
            do_adv = 1'b1;
          end else begin
            cnt_d = cnt_q - DUR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      gate_d  = 1'b0;
      done_d  = 1'b1;
      state_d = IDLE;
    end
    if (do_adv) begin
      if (!last) begin
        step_d  = step_nx[AW-1:0];
        state_d = LOAD;
      end else if (loop_q) begin
        step_d  = '0;
        state_d = LOAD;
      end else begin
        gate_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      len_q   <= '0;
      loop_q  <= 1'b0;
      step_q  <= '0;
      cnt_q   <= '0;
      wave_q  <= '0;
      freq_q  <= '0;
      gate_q  <= 1'b0;
      adv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      wave_q  <= wave_d;
      freq_q  <= freq_d;
      gate_q  <= gate_d;
      adv_q   <= adv_d;
      done_q  <= done_d;
    end
  end

  assign wave_sel_o = wave_q;
  assign freq_sel_o = freq_q;
  assign gate_o     = gate_q;
  assign step_o     = step_q;
  assign step_adv_o = adv_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: scoreboard of expected step records,
// consumed on each step_adv_o pulse, plus per-scenario checks.
module tb_tone_sequencer;
  localparam int DEPTH  = 16;
  localparam int DUR_W  = 16;
  localparam int FREQ_W = 4;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [1:0]        cfg_wave = '0;
  logic [FREQ_W-1:0] cfg_freq = '0;
  logic              cfg_rest = 1'b0;
  logic [DUR_W-1:0]  cfg_dur = '0;
  logic [AW:0]       len = '0;
  logic              loop_en = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              tick = 1'b0;
  logic [1:0]        wave_sel;
  logic [FREQ_W-1:0] freq_sel;
  logic              gate;
  logic [AW-1:0]     step;
  logic              step_adv;
  logic              busy;
  logic              done;

  typedef logic [10:0] rec_t;

  rec_t exp_q[$];
  int   tk_q[$];
  rec_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   adv_cnt = 0;
  int   done_cnt = 0;
  int   tick_cnt = 0;

  always #5 clk = ~clk;

  tone_sequencer #(
    .DEPTH(DEPTH),
    .DUR_W(DUR_W),
    .FREQ_W(FREQ_W)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cfg_we_i(cfg_we),
    .cfg_addr_i(cfg_addr),
    .cfg_wave_i(cfg_wave),
    .cfg_freq_i(cfg_freq),
    .cfg_rest_i(cfg_rest),
    .cfg_dur_i(cfg_dur),
    .len_i(len),
    .loop_i(loop_en),
    .start_i(start),
    .stop_i(stop),
    .sample_tick_i(tick),
    .wave_sel_o(wave_sel),
    .freq_sel_o(freq_sel),
    .gate_o(gate),
    .step_o(step),
    .step_adv_o(step_adv),
    .busy_o(busy),
    .done_o(done)
  );

  function automatic rec_t mk(input int w, input int f,
                              input int g, input int s);
    return {w[1:0], f[3:0], g[0], s[3:0]};
  endfunction

  // scoreboard consumer: every step_adv pulse pops one expected record
  always @(posedge clk) begin
    #1;
    if (rst_n && step_adv) begin
      adv_cnt++;
      tk_q.push_back(tick_cnt);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL adv_unexpected got=%h want=none",
                 {wave_sel, freq_sel, gate, step});
      end else begin
        mon_e = exp_q.pop_front();
        if ({wave_sel, freq_sel, gate, step} !== mon_e) begin
          errors++;
          $display("FAIL adv_record got=%h want=%h",
                   {wave_sel, freq_sel, gate, step}, mon_e);
        end
      end
    end
    if (rst_n && done) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wr(input int a, input int w, input int f,
                    input int r, input int d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a[3:0];
    cfg_wave = w[1:0];
    cfg_freq = f[3:0];
    cfg_rest = r[0];
    cfg_dur  = d[15:0];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic start_seq(input int l, input bit lp);
    @(negedge clk);
    len     = l[4:0];
    loop_en = lp;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic tick_run(input int per, input int max,
                          input int t_adv, input int t_done,
                          output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      @(negedge clk);
      if ((t_adv > 0 && adv_cnt >= t_adv) ||
          (t_done > 0 && done_cnt >= t_done)) begin
        ok = 1'b1;
        break;
      end
      tick = (c % per == per - 1);
      if (tick) tick_cnt++;
    end
    tick = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({wave_sel, freq_sel, gate, step, step_adv, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0",
               {wave_sel, freq_sel, gate, step, step_adv, busy, done});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b done=%b want=0,0", busy, done);
    end
  endtask

  task automatic test_one_shot();
    int a0, d0;
    bit ok, bad;
    for (int i = 0; i < 4; i++) wr(i, i, 5, 0, 3);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 5, 1, i));
    a0 = adv_cnt;
    d0 = done_cnt;
    tick_cnt = 0;
    tk_q.delete();
    start_seq(4, 1'b0);
    tick_run(4, 400, 0, d0 + 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL oneshot_timeout got=no_done want=done");
    end
    checks++;
    if (adv_cnt - a0 != 4) begin
      errors++;
      $display("FAIL oneshot_adv got=%0d want=4", adv_cnt - a0);
    end
    checks++;
    if (tick_cnt != 12) begin
      errors++;
      $display("FAIL oneshot_ticks got=%0d want=12", tick_cnt);
    end
    bad = (tk_q.size() != 4);
    for (int i = 1; i < 4 && !bad; i++)
      if (tk_q[i] - tk_q[i-1] != 3) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL oneshot_step_len got=%p want=3 ticks each", tk_q);
    end
    checks++;
    if (gate !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_end gate=%b busy=%b done=%b want=0,0,1",
               gate, busy, done);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL oneshot_done_once got=%0d,%0d want=%0d,0",
               done_cnt - d0, exp_q.size(), 1);
    end
  endtask

  task automatic test_rest_skip();
    int a0, d0;
    bit ok;
    wr(0, 1, 2, 0, 2);
    wr(1, 3, 7, 1, 2);
    wr(2, 0, 0, 0, 0);
    exp_q.push_back(mk(1, 2, 1, 0));
    exp_q.push_back(mk(3, 7, 0, 1));
    a0 = adv_cnt;
    d0 = done_cnt;
    tick_cnt = 0;
    start_seq(3, 1'b0);
    tick_run(4, 300, 0, d0 + 1, ok);
    checks++;
    if (!ok || adv_cnt - a0 != 2) begin
      errors++;
      $display("FAIL rest_adv ok=%b got=%0d want=2", ok, adv_cnt - a0);
    end
    checks++;
    if (tick_cnt != 4) begin
      errors++;
      $display("FAIL rest_ticks got=%0d want=4", tick_cnt);
    end
    checks++;
    if (wave_sel !== 2'd3 || freq_sel !== 4'd7 || gate !== 1'b0) begin
      errors++;
      $display("FAIL rest_skip_hold got=%0d,%0d,%b want=3,7,0",
               wave_sel, freq_sel, gate);
    end
  endtask

  task automatic test_timing();
    wr(0, 2, 9, 0, 1);
    exp_q.push_back(mk(2, 9, 1, 0));
    @(negedge clk);
    len     = 5'd1;
    loop_en = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || step_adv !== 1'b0) begin
      errors++;
      $display("FAIL timing_load busy=%b adv=%b want=1,0", busy, step_adv);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (step_adv !== 1'b1 || gate !== 1'b1) begin
      errors++;
      $display("FAIL timing_adv adv=%b gate=%b want=1,1", step_adv, gate);
    end
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || gate !== 1'b0) begin
      errors++;
      $display("FAIL timing_dur1 done=%b busy=%b gate=%b want=1,0,0",
               done, busy, gate);
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic test_loop_stop();
    int a0, d0;
    bit ok;
    wr(0, 0, 1, 0, 2);
    wr(1, 1, 2, 0, 2);
    exp_q.push_back(mk(0, 1, 1, 0));
    exp_q.push_back(mk(1, 2, 1, 1));
    a0 = adv_cnt;
    d0 = done_cnt;
    start_seq(2, 1'b1);
    tick_run(4, 100, a0 + 1, 0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL loop_first got=no_adv want=adv");
    end
    wr(0, 0, 12, 0, 2);
    checks++;
    if (freq_sel !== 4'd1) begin
      errors++;
      $display("FAIL loop_write_live got=%0d want=1", freq_sel);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(0, 12, 1, 0));
      exp_q.push_back(mk(1, 2, 1, 1));
    end
    tick_run(4, 400, a0 + 6, 0, ok);
    checks++;
    if (!ok || done_cnt != d0) begin
      errors++;
      $display("FAIL loop_wrap ok=%b done=%0d want=1,0", ok, done_cnt - d0);
    end
    len   = 5'd2;
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || gate !== 1'b0) begin
      errors++;
      $display("FAIL stop_abort done=%b busy=%b gate=%b want=1,0,0",
               done, busy, gate);
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stop_wins busy=%b done=%b left=%0d want=0,0,0",
               busy, done, exp_q.size());
    end
  endtask

  task automatic test_len_zero();
    @(negedge clk);
    len   = 5'd0;
    start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_done done=%b busy=%b want=1,0", done, busy);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_after done=%b busy=%b want=0,0", done, busy);
    end
  endtask

  task automatic test_clamp();
    int a0, d0;
    bit ok;
    for (int i = 0; i < 16; i++) wr(i, i % 4, i, 0, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(i % 4, i, 1, i));
    a0 = adv_cnt;
    d0 = done_cnt;
    start_seq(31, 1'b0);
    tick_run(4, 800, 0, d0 + 1, ok);
    checks++;
    if (!ok || adv_cnt - a0 != 16) begin
      errors++;
      $display("FAIL clamp_adv ok=%b got=%0d want=16", ok, adv_cnt - a0);
    end
    checks++;
    if (step !== 4'd15 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL clamp_last got=%0d left=%0d want=15,0",
               step, exp_q.size());
    end
  endtask

  task automatic test_spin();
    int a0, d0;
    wr(0, 1, 1, 0, 0);
    wr(1, 2, 2, 0, 0);
    a0 = adv_cnt;
    d0 = done_cnt;
    start_seq(2, 1'b1);
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || adv_cnt != a0 || done_cnt != d0) begin
      errors++;
      $display("FAIL spin busy=%b adv=%0d done=%0d want=1,0,0",
               busy, adv_cnt - a0, done_cnt - d0);
    end
    stop = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL spin_stop done=%b busy=%b want=1,0", done, busy);
    end
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic test_reset_midplay();
    int a0;
    bit ok;
    wr(0, 3, 11, 0, 100);
    exp_q.push_back(mk(3, 11, 1, 0));
    a0 = adv_cnt;
    start_seq(1, 1'b0);
    tick_run(4, 60, a0 + 1, 0, ok);
    checks++;
    if (!ok || gate !== 1'b1) begin
      errors++;
      $display("FAIL midplay_setup ok=%b gate=%b want=1,1", ok, gate);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wave_sel, freq_sel, gate, step, step_adv, busy, done} !== '0) begin
      errors++;
      $display("FAIL midplay_async got=%h want=0",
               {wave_sel, freq_sel, gate, step, step_adv, busy, done});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || gate !== 1'b0) begin
      errors++;
      $display("FAIL midplay_release busy=%b gate=%b want=0,0", busy, gate);
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_rest_skip();
    test_timing();
    test_loop_stop();
    test_len_zero();
    test_clamp();
    test_spin();
    test_reset_midplay();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
